// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency instruction ROM port between two cores.
// Faulted fetches (misaligned or out of range) never reach the ROM and are answered with a tagged NOP.
module imem_arbiter #(
  parameter int unsigned IMEM_BYTES = 32'd4096,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter int unsigned CNT_W      = 32'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c0_req,
  input  logic [31:0]      c0_pc,
  output logic             c0_gnt,
  output logic             c0_rvalid,
  output logic [31:0]      c0_rdata,
  output logic             c0_err,
  input  logic             c1_req,
  input  logic [31:0]      c1_pc,
  output logic             c1_gnt,
  output logic             c1_rvalid,
  output logic [31:0]      c1_rdata,
  output logic             c1_err,
  output logic             mem_en,
  output logic [31:0]      mem_pc,
  input  logic [31:0]      mem_instr,
  output logic [CNT_W-1:0] c0_gnt_cnt,
  output logic [CNT_W-1:0] c1_gnt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'(IMEM_BYTES));
  endfunction

  logic             last_q, last_d;
  logic             resp_v_q, resp_v_d;
  logic             resp_id_q, resp_id_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] c0_cnt_q, c0_cnt_d;
  logic [CNT_W-1:0] c1_cnt_q, c1_cnt_d;
  logic             gnt0_s, gnt1_s, any_gnt_s, fault_s;
  logic [31:0]      sel_pc_s;

  // Grant selection; last_q holds the id of the most recently granted core.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (c0_req && c1_req) begin
      gnt0_s = last_q;
      gnt1_s = ~last_q;
    end else if (c0_req) begin
      gnt0_s = 1'b1;
    end else if (c1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Fault check and ROM drive for the granted fetch.
  always_comb begin
    any_gnt_s = gnt0_s | gnt1_s;
    sel_pc_s  = gnt1_s ? c1_pc : c0_pc;
    fault_s   = any_gnt_s & fetch_fault(sel_pc_s);
    mem_en    = any_gnt_s & ~fault_s;
    if (any_gnt_s) begin
      mem_pc = sel_pc_s;
    end else begin
      mem_pc = 32'h0000_0000;
    end
  end

  // Next-state for pointer, response stage and saturating grant counters.
  always_comb begin
    if (gnt1_s) begin
      last_d = 1'b1;
    end else if (gnt0_s) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
    resp_v_d   = any_gnt_s;
    resp_id_d  = gnt1_s;
    resp_err_d = fault_s;
    if (gnt0_s && (c0_cnt_q != CNT_MAX)) begin
      c0_cnt_d = c0_cnt_q + CNT_W'(1);
    end else begin
      c0_cnt_d = c0_cnt_q;
    end
    if (gnt1_s && (c1_cnt_q != CNT_MAX)) begin
      c1_cnt_d = c1_cnt_q + CNT_W'(1);
    end else begin
      c1_cnt_d = c1_cnt_q;
    end
  end

  // State registers; an in-flight response is dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      resp_v_q   <= 1'b0;
      resp_id_q  <= 1'b0;
      resp_err_q <= 1'b0;
      c0_cnt_q   <= '0;
      c1_cnt_q   <= '0;
    end else begin
      last_q     <= last_d;
      resp_v_q   <= resp_v_d;
      resp_id_q  <= resp_id_d;
      resp_err_q <= resp_err_d;
      c0_cnt_q   <= c0_cnt_d;
      c1_cnt_q   <= c1_cnt_d;
    end
  end

  // Response routing; rdata and err are zero whenever rvalid is low.
  always_comb begin
    c0_rvalid = resp_v_q & ~resp_id_q;
    c1_rvalid = resp_v_q & resp_id_q;
    c0_err    = c0_rvalid & resp_err_q;
    c1_err    = c1_rvalid & resp_err_q;
    if (c0_rvalid) begin
      c0_rdata = resp_err_q ? NOP_WORD : mem_instr;
    end else begin
      c0_rdata = 32'h0000_0000;
    end
    if (c1_rvalid) begin
      c1_rdata = resp_err_q ? NOP_WORD : mem_instr;
    end else begin
      c1_rdata = 32'h0000_0000;
    end
  end

  assign c0_gnt     = gnt0_s;
  assign c1_gnt     = gnt1_s;
  assign c0_gnt_cnt = c0_cnt_q;
  assign c1_gnt_cnt = c1_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table plus reset-drop and counter-saturation sequences.
module tb_imem_arbiter;

  localparam logic [31:0] W0  = 32'h0010_0313;
  localparam logic [31:0] W8  = 32'h0010_031B;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_req = 1'b0, c1_req = 1'b0;
  logic [31:0] c0_pc = 32'h0, c1_pc = 32'h0;
  logic        c0_gnt, c0_rvalid, c0_err, c1_gnt, c1_rvalid, c1_err, mem_en;
  logic [31:0] c0_rdata, c1_rdata, mem_pc;
  logic [31:0] mem_instr = 32'h0;
  logic [15:0] c0_gnt_cnt, c1_gnt_cnt;

  logic        s_req = 1'b0;
  logic        s_zero = 1'b0;
  logic [31:0] s_pc = 32'h20, s_zpc = 32'h0, s_instr = 32'h0;
  logic        s_g0, s_rv0, s_er0, s_g1, s_rv1, s_er1, s_men;
  logic [31:0] s_rd0, s_rd1, s_mpc;
  logic [3:0]  s_cnt0, s_cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_pc(c0_pc), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
    .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_pc(c1_pc), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
    .c1_rdata(c1_rdata), .c1_err(c1_err),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_instr(mem_instr),
    .c0_gnt_cnt(c0_gnt_cnt), .c1_gnt_cnt(c1_gnt_cnt)
  );

  imem_arbiter #(.CNT_W(32'd4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .c0_req(s_zero), .c0_pc(s_zpc), .c0_gnt(s_g0), .c0_rvalid(s_rv0),
    .c0_rdata(s_rd0), .c0_err(s_er0),
    .c1_req(s_req), .c1_pc(s_pc), .c1_gnt(s_g1), .c1_rvalid(s_rv1),
    .c1_rdata(s_rd1), .c1_err(s_er1),
    .mem_en(s_men), .mem_pc(s_mpc), .mem_instr(s_instr),
    .c0_gnt_cnt(s_cnt0), .c1_gnt_cnt(s_cnt1)
  );

  // ROM model: word at byte address pc is W0 + pc, registered one cycle after en.
  always_ff @(posedge clk) begin
    if (mem_en) mem_instr <= W0 + mem_pc;
  end

  typedef struct {
    logic        r0;  logic [31:0] p0;
    logic        r1;  logic [31:0] p1;
    logic        g0, g1, men;
    logic [31:0] mpc;
    logic        rv0, er0; logic [31:0] rd0;
    logic        rv1, er1; logic [31:0] rd1;
    logic [15:0] cn0, cn1;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(int r0, int p0, int r1, int p1, int g0, int g1, int men, int mpc,
                              int rv0, int er0, int rd0, int rv1, int er1, int rd1,
                              int cn0, int cn1);
    vec_t v;
    v.r0 = r0[0]; v.p0 = 32'(p0); v.r1 = r1[0]; v.p1 = 32'(p1);
    v.g0 = g0[0]; v.g1 = g1[0]; v.men = men[0]; v.mpc = 32'(mpc);
    v.rv0 = rv0[0]; v.er0 = er0[0]; v.rd0 = 32'(rd0);
    v.rv1 = rv1[0]; v.er1 = er1[0]; v.rd1 = 32'(rd1);
    v.cn0 = 16'(cn0); v.cn1 = 16'(cn1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " c0_gnt"}, {31'h0, c0_gnt}, 32'h0);
    chk({tag, " c1_gnt"}, {31'h0, c1_gnt}, 32'h0);
    chk({tag, " c0_rvalid"}, {31'h0, c0_rvalid}, 32'h0);
    chk({tag, " c1_rvalid"}, {31'h0, c1_rvalid}, 32'h0);
    chk({tag, " c0_err"}, {31'h0, c0_err}, 32'h0);
    chk({tag, " c1_err"}, {31'h0, c1_err}, 32'h0);
    chk({tag, " c0_rdata"}, c0_rdata, 32'h0);
    chk({tag, " c1_rdata"}, c1_rdata, 32'h0);
    chk({tag, " mem_en"}, {31'h0, mem_en}, 32'h0);
    chk({tag, " mem_pc"}, mem_pc, 32'h0);
    chk({tag, " c0_gnt_cnt"}, {16'h0, c0_gnt_cnt}, 32'h0);
    chk({tag, " c1_gnt_cnt"}, {16'h0, c1_gnt_cnt}, 32'h0);
  endtask

  initial begin
    //           r0 p0     r1 p1  g0 g1 men mpc     rv0 er0 rd0          rv1 er1 rd1   cn0 cn1
    vecs[0]  = mk(1, 0,     1, 8, 1, 0, 1, 0,      0, 0, 0,            0, 0, 0,      0, 0);
    vecs[1]  = mk(1, 0,     1, 8, 0, 1, 1, 8,      1, 0, W0,           0, 0, 0,      1, 0);
    vecs[2]  = mk(1, 0,     1, 8, 1, 0, 1, 0,      0, 0, 0,            1, 0, W8,     1, 1);
    vecs[3]  = mk(1, 0,     1, 8, 0, 1, 1, 8,      1, 0, W0,           0, 0, 0,      2, 1);
    vecs[4]  = mk(1, 0,     1, 8, 1, 0, 1, 0,      0, 0, 0,            1, 0, W8,     2, 2);
    vecs[5]  = mk(1, 0,     1, 8, 0, 1, 1, 8,      1, 0, W0,           0, 0, 0,      3, 2);
    vecs[6]  = mk(0, 0,     1, 6, 0, 1, 0, 6,      0, 0, 0,            1, 0, W8,     3, 3);
    vecs[7]  = mk(1, 'h1000, 0, 0, 1, 0, 0, 'h1000, 0, 0, 0,            1, 1, NOP,    3, 4);
    vecs[8]  = mk(1, 'hFFC, 0, 0, 1, 0, 1, 'hFFC,  1, 1, NOP,          0, 0, 0,      4, 4);
    vecs[9]  = mk(0, 0,     0, 0, 0, 0, 0, 0,      1, 0, 'h0010130F,   0, 0, 0,      5, 4);
    vecs[10] = mk(0, 0,     1, 3, 0, 1, 0, 3,      0, 0, 0,            0, 0, 0,      5, 4);
    vecs[11] = mk(1, 0,     1, 4, 1, 0, 1, 0,      0, 0, 0,            1, 1, NOP,    5, 5);
    vecs[12] = mk(1, 4,     0, 0, 1, 0, 1, 4,      1, 0, W0,           0, 0, 0,      6, 5);
    vecs[13] = mk(0, 0,     0, 0, 0, 0, 0, 0,      1, 0, 'h00100317,   0, 0, 0,      7, 5);

    // Reset with both requests high: grants must stay low.
    c0_req = 1'b1; c1_req = 1'b1;
    #6;
    chk_all_zero("reset");
    @(negedge clk);
    c0_req = 1'b0; c1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      c0_req = vecs[i].r0; c0_pc = vecs[i].p0;
      c1_req = vecs[i].r1; c1_pc = vecs[i].p1;
      #1;
      chk($sformatf("v%0d c0_gnt", i), {31'h0, c0_gnt}, {31'h0, vecs[i].g0});
      chk($sformatf("v%0d c1_gnt", i), {31'h0, c1_gnt}, {31'h0, vecs[i].g1});
      chk($sformatf("v%0d mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].men});
      chk($sformatf("v%0d mem_pc", i), mem_pc, vecs[i].mpc);
      chk($sformatf("v%0d c0_rvalid", i), {31'h0, c0_rvalid}, {31'h0, vecs[i].rv0});
      chk($sformatf("v%0d c0_err", i), {31'h0, c0_err}, {31'h0, vecs[i].er0});
      chk($sformatf("v%0d c0_rdata", i), c0_rdata, vecs[i].rd0);
      chk($sformatf("v%0d c1_rvalid", i), {31'h0, c1_rvalid}, {31'h0, vecs[i].rv1});
      chk($sformatf("v%0d c1_err", i), {31'h0, c1_err}, {31'h0, vecs[i].er1});
      chk($sformatf("v%0d c1_rdata", i), c1_rdata, vecs[i].rd1);
      chk($sformatf("v%0d c0_gnt_cnt", i), {16'h0, c0_gnt_cnt}, {16'h0, vecs[i].cn0});
      chk($sformatf("v%0d c1_gnt_cnt", i), {16'h0, c1_gnt_cnt}, {16'h0, vecs[i].cn1});
    end

    // Reset between a grant and its response drops the response.
    @(negedge clk);
    c0_req = 1'b1; c0_pc = 32'h10; c1_req = 1'b0;
    #1;
    chk("rd c0_gnt", {31'h0, c0_gnt}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    c0_pc = 32'h0; c1_req = 1'b1; c1_pc = 32'h8;
    #1;
    chk_all_zero("mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel c0_rvalid", {31'h0, c0_rvalid}, 32'h0);
    chk("rel tie c0_gnt", {31'h0, c0_gnt}, 32'h1);
    chk("rel tie c1_gnt", {31'h0, c1_gnt}, 32'h0);
    chk("rel mem_pc", mem_pc, 32'h0);
    @(negedge clk);
    c0_req = 1'b0; c1_req = 1'b0;
    #1;
    chk("rel resp c0_rvalid", {31'h0, c0_rvalid}, 32'h1);
    chk("rel resp c0_rdata", c0_rdata, W0);
    chk("rel resp c1_rvalid", {31'h0, c1_rvalid}, 32'h0);

    // Saturation with a 4-bit counter: core 1 alone for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_req = 1'b1;
      #1;
      chk($sformatf("sat%0d c1_gnt_cnt", i), {28'h0, s_cnt1}, (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("sat%0d c1_gnt", i), {31'h0, s_g1}, 32'h1);
    end
    @(negedge clk);
    s_req = 1'b0;
    #1;
    chk("sat final c1_gnt_cnt", {28'h0, s_cnt1}, 32'd15);
    chk("sat final c0_gnt_cnt", {28'h0, s_cnt0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency instruction ROM port between core 0 and core 1 of the dual-core RV32 design.
- Performs round-robin arbitration on fetch requests and drives the shared ROM's en/pc inputs.
- Routes the registered instruction word back to the winning core.
- Traps misaligned and out-of-range fetches locally and answers them with an error-tagged NOP.
- Keeps per-core saturating grant counters for performance debug.

Parameters:
IMEM_BYTES, 4096, ROM size in bytes; valid fetch range is 0 .. IMEM_BYTES-1.
NOP_WORD, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0).
CNT_W, 16, width of each per-core grant counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
c0_req  in  1  core 0 fetch request
c0_pc  in  32  core 0 fetch byte address
c0_gnt  out  1  core 0 request accepted this cycle
c0_rvalid  out  1  core 0 response valid
c0_rdata  out  32  core 0 instruction word
c0_err  out  1  core 0 fetch fault (misaligned or out of range)
c1_req, c1_pc, c1_gnt, c1_rvalid, c1_rdata, c1_err  as core 0, for core 1
mem_en  out  1  shared ROM read enable
mem_pc  out  32  shared ROM byte address
mem_instr  in  32  shared ROM registered output, valid the cycle after mem_en
c0_gnt_cnt  out  CNT_W  core 0 grants since reset, saturating
c1_gnt_cnt  out  CNT_W  core 1 grants since reset, saturating

Behaviour:
- Requester handshake: holds cX_req=1 and cX_pc stable until it sees cX_gnt=1 on a rising edge. The request is consumed on that edge.
- Grant logic:
  - cX_gnt is combinational from the requests and the last-grant pointer.
  - At most one grant per cycle; c0_gnt and c1_gnt are never both 1.
  - Only one core requesting: that core is granted.
  - Both cores requesting: the core not equal to the last-grant pointer is granted.
  - The last-grant pointer updates on every grant and resets to 1, so core 0 wins the first tie.
  - Both cores requesting every cycle: grants alternate 0,1,0,1; no core waits more than 1 cycle.
- Fault check:
  - fault = (pc[1:0] != 0) or (pc >= IMEM_BYTES), evaluated on the granted pc.
- Memory drive:
  - mem_en = grant and not fault.
  - mem_pc = granted core's pc when a grant is issued, else 0.
  - Both are combinational.
- Response stage: registers resp_v, resp_id and resp_err on every edge.
  - resp_v = any grant; resp_id = granted core; resp_err = fault.
- Outputs in the cycle after a grant:
  - cX_rvalid = resp_v and resp_id==X.
  - cX_rdata = NOP_WORD if resp_err, else mem_instr.
  - cX_err = resp_v and resp_id==X and resp_err.
  - When cX_rvalid=0: cX_rdata=0 and cX_err=0.
- Timing:
  - Latency: exactly 1 cycle from grant edge to rvalid.
  - Throughput: 1 response per cycle in aggregate.
  - No internal buffering: the requester must accept rvalid; there is no back-pressure.
- Counters:
  - cX_gnt_cnt increments on each cX grant.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset (rst_n low, asynchronous):
  - All outputs 0: gnt, rvalid, err, rdata, mem_en, mem_pc, counters.
  - Pointer = 1; response stage cleared.
  - Grants are forced to 0 while rst_n is low, even if req is high.
  - Reset asserted between a grant and its response: the response is dropped; no rvalid appears after release.
- Edge cases:
  - Request arriving in the same cycle a response is delivered to the same core is legal; it is granted normally.
  - A fault grant still advances the pointer and the counter.

Test Plan:
1. Reset then c0_req=1, c0_pc=0, mem_instr=32'h00100313 on the next cycle -> c0_gnt=1 and mem_en=1, mem_pc=0 that cycle; next cycle c0_rvalid=1, c0_rdata=32'h00100313, c0_err=0, c1_rvalid=0.
2. Both cores request continuously for 6 cycles (c0_pc=0x0, c1_pc=0x8) -> grant order 0,1,0,1,0,1; each rvalid follows its grant by 1 cycle with the matching ROM word; c0_gnt_cnt=3, c1_gnt_cnt=3.
3. c1_req with c1_pc=0x6 -> c1_gnt=1 and mem_en=0; next cycle c1_rvalid=1, c1_err=1, c1_rdata=32'h00000013.
4. c0_req with c0_pc=0x1000 (IMEM_BYTES=4096) -> same fault response on core 0; pc=0xFFC -> normal fetch with err=0.
5. Grant c0 at edge N, rst_n pulsed low before edge N+1 -> c0_rvalid stays 0; all outputs 0 during reset; after release the first tie goes to core 0.
6. CNT_W=4, core 1 requests alone for 20 cycles -> c1_gnt_cnt reaches 15 and holds; c0_gnt_cnt=0.
